seq_stream_checker: RTL and testbench
=====================================

Name: seq_stream_checker

Overview:
- Receive-side checker for the 4-bit valid-qualified sequence stream produced by the counter/sequence generator top (q_out, valid).
- Samples each valid word, predicts the next word (previous + STEP, modulo 2^WIDTH), acquires lock, flags mismatches and keeps match/error statistics.
- Sits at the consumer end of the generator's output. Used in-system and as a self-checking monitor on the generator.

Parameters:
- WIDTH, 4, data word width; matches the generator's q_out.
- STEP, 1, expected increment between consecutive valid words, modulo 2^WIDTH.
- LOCK_CNT, 3, consecutive in-sequence words required to declare lock; range 1..15.
- LOSS_CNT, 2, consecutive mismatches while locked that drop lock; range 1..15.
- CNT_W, 8, width of the statistics counters.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- q_in  input  WIDTH  received data word.
- valid_in  input  1  q_in is valid this cycle.
- clear  input  1  synchronous clear of match_cnt and err_cnt only.
- locked  output  1  checker is in lock (state LOCKED or SLIP).
- err  output  1  one-cycle pulse per mismatch detected while locked.
- exp_out  output  WIDTH  current expected next word.
- match_cnt  output  CNT_W  count of in-sequence words received while locked; saturating.
- err_cnt  output  CNT_W  count of mismatches received while locked; saturating.

Behaviour:
- All outputs are registered and update on the clk edge that samples the word. They are visible in the following cycle.
- Reset (synchronous, active-high) clears every output to 0 and sets state to SEARCH. This applies mid-stream too: a word presented in the reset cycle is ignored.
- If valid_in=0, state, exp, counters and err are unchanged, except that err returns to 0.
- All arithmetic is modulo 2^WIDTH. With STEP=1, the wrap 15->0 is a match.
- A "match" means q_in == exp.
- SEARCH state, on a valid word:
  - exp <= q_in+STEP; good <= 1.
  - Go to LOCKED if LOCK_CNT==1, otherwise go to SYNC.
- SYNC state, on a valid word:
  - On a match: exp <= q_in+STEP; good <= good+1. Go to LOCKED when good+1 == LOCK_CNT.
  - On a mismatch: reseed with exp <= q_in+STEP and good <= 1; stay in SYNC. No err, no count.
- LOCKED state, on a valid word:
  - On a match: match_cnt+1; exp <= exp+STEP.
  - On a mismatch: err=1; err_cnt+1; bad <= 1; exp <= exp+STEP (the prediction keeps free-running and does not reseed). Go to SEARCH if LOSS_CNT==1, otherwise go to SLIP.
- SLIP state, on a valid word:
  - On a match: match_cnt+1; bad <= 0; go to LOCKED.
  - On a mismatch: err=1; err_cnt+1; bad <= bad+1. Go to SEARCH when bad+1 == LOSS_CNT (locked falls).
- locked goes high in the cycle after the LOCK_CNT-th consecutive good word. It stays high through SLIP.
- Counters saturate at all ones and do not wrap.
- If clear and an increment occur in the same cycle, clear wins: the counter becomes 0.
- clear does not affect state, exp, err or locked.
- Internal counters good and bad are 4 bits wide.

Optional Feature:
- Macro: SEQ_CHECK_LOG_EN.
- When defined, two extra outputs are added:
  - bad_word (WIDTH): the q_in value of the most recent counted mismatch.
  - bad_exp (WIDTH): the exp value at that same mismatch.
  - Both are updated in the same cycle as the err pulse and reset to 0. clear does not affect them.
- When undefined, these ports and their registers do not exist, and all other behaviour is identical.

Test Plan:
1. Reset 2 cycles, then valid words 0,1,2,3,4 on consecutive cycles -> locked=1 the cycle after word 2; match_cnt=2 after word 4; err_cnt=0; exp_out=5.
2. While locked, send 13,14,15,0,1 -> no err pulses; exp_out goes 14,15,0,1,2; match_cnt increments by 5.
3. While locked with exp=7, send 9 then 8 -> err pulses once; err_cnt=1; state passes through SLIP and returns to LOCKED; locked stays 1; match_cnt+1 on the 8.
4. While locked with exp=7, send 3,3 -> two err pulses; err_cnt+2; locked=0 the cycle after the second 3. Then send 10,11,12 -> locked=1 again after the 12.
5. While locked, drop valid_in for 5 cycles with q_in toggling randomly -> no change in exp_out, counters or locked. Resuming with the expected word gives a match.
6. With CNT_W=4, send 20 in-sequence words -> match_cnt holds at 15. Then assert clear together with a matching word -> match_cnt=0. Assert reset mid-stream -> all outputs 0 and state SEARCH; relock requires LOCK_CNT new words.

Source files
------------

// File: rtl/seq_stream_checker.sv
// rtl/seq_stream_checker.sv - receive-side lock/mismatch checker for a valid-qualified sequence stream
//
// Purpose:
//   Samples each valid word, predicts the next one (previous + STEP modulo
//   2^WIDTH), acquires lock after LOCK_CNT consecutive in-sequence words,
//   drops lock after LOSS_CNT consecutive mismatches, pulses err on every
//   mismatch seen while locked and keeps saturating match/error statistics.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   q_in       in   [WIDTH-1:0] received word
//   valid_in   in   q_in is valid this cycle
//   clear      in   synchronous clear of match_cnt and err_cnt only
//   locked     out  checker is in LOCKED or SLIP
//   err        out  one-cycle pulse per mismatch detected while locked
//   exp_out    out  [WIDTH-1:0] current expected next word
//   match_cnt  out  [CNT_W-1:0] saturating count of in-sequence words while locked
//   err_cnt    out  [CNT_W-1:0] saturating count of mismatches while locked
//   bad_word   out  [WIDTH-1:0] q_in of the latest counted mismatch (SEQ_CHECK_LOG_EN only)
//   bad_exp    out  [WIDTH-1:0] expected word at that mismatch (SEQ_CHECK_LOG_EN only)
//
// Optional feature macro: SEQ_CHECK_LOG_EN (adds bad_word / bad_exp).

module seq_stream_checker #(
    parameter int WIDTH    = 4,
    parameter int STEP     = 1,
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] q_in,
    input  logic             valid_in,
    input  logic             clear,
    output logic             locked,
    output logic             err,
    output logic [WIDTH-1:0] exp_out,
    output logic [CNT_W-1:0] match_cnt,
`ifdef SEQ_CHECK_LOG_EN
    output logic [CNT_W-1:0] err_cnt,
    output logic [WIDTH-1:0] bad_word,
    output logic [WIDTH-1:0] bad_exp
`else
    output logic [CNT_W-1:0] err_cnt
`endif
);

    // LOCKED and SLIP share bit 1 so that locked is a direct state decode.
    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [1:0] ST_SLIP   = 2'd3;

    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [3:0]       LOCK_C  = 4'(LOCK_CNT);
    localparam logic [3:0]       LOSS_C  = 4'(LOSS_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] exp_nxt;
    logic [3:0]       good;
    logic [3:0]       good_nxt;
    logic [3:0]       bad;
    logic [3:0]       bad_nxt;
    logic             err_nxt;
    logic             match_inc;
    logic             err_inc;

    logic             is_match;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] exp_adv;
    logic [3:0]       good_inc;
    logic [3:0]       bad_inc;

    assign is_match = (q_in == exp_q);
    assign seed     = q_in + STEP_W;
    assign exp_adv  = exp_q + STEP_W;
    assign good_inc = good + 4'd1;
    assign bad_inc  = bad + 4'd1;

    always_comb begin
        state_nxt = state;
        exp_nxt   = exp_q;
        good_nxt  = good;
        bad_nxt   = bad;
        err_nxt   = 1'b0;
        match_inc = 1'b0;
        err_inc   = 1'b0;

        if (valid_in) begin
            case (state)
                ST_SEARCH: begin
                    exp_nxt   = seed;
                    good_nxt  = 4'd1;
                    state_nxt = (LOCK_C == 4'd1) ? ST_LOCKED : ST_SYNC;
                end
                ST_SYNC: begin
                    // Before lock every word reseeds the prediction; only the
                    // run length of consecutive good words depends on a match.
                    exp_nxt = seed;
                    if (is_match) begin
                        good_nxt = good_inc;
                        if (good_inc == LOCK_C) begin
                            state_nxt = ST_LOCKED;
                        end
                    end else begin
                        good_nxt = 4'd1;
                    end
                end
                ST_LOCKED: begin
                    // Once locked the prediction free-runs and never reseeds
                    // from received data, so a single corrupt word cannot
                    // shift the expected sequence.
                    exp_nxt = exp_adv;
                    if (is_match) begin
                        match_inc = 1'b1;
                    end else begin
                        err_nxt   = 1'b1;
                        err_inc   = 1'b1;
                        bad_nxt   = 4'd1;
                        state_nxt = (LOSS_C == 4'd1) ? ST_SEARCH : ST_SLIP;
                    end
                end
                default: begin
                    exp_nxt = exp_adv;
                    if (is_match) begin
                        match_inc = 1'b1;
                        bad_nxt   = 4'd0;
                        state_nxt = ST_LOCKED;
                    end else begin
                        err_nxt = 1'b1;
                        err_inc = 1'b1;
                        bad_nxt = bad_inc;
                        if (bad_inc == LOSS_C) begin
                            state_nxt = ST_SEARCH;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_SEARCH;
            exp_q <= '0;
            good  <= '0;
            bad   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            exp_q <= exp_nxt;
            good  <= good_nxt;
            bad   <= bad_nxt;
            err   <= err_nxt;
        end
    end

    // Statistics: clear has priority over a same-cycle increment, and the
    // counters stick at all ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            match_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (match_inc && (match_cnt != CNT_MAX)) begin
                match_cnt <= match_cnt + 1'b1;
            end
            if (err_inc && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

`ifdef SEQ_CHECK_LOG_EN
    // Capture log follows the err pulse; clear leaves it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            bad_word <= '0;
            bad_exp  <= '0;
        end else if (err_nxt) begin
            bad_word <= q_in;
            bad_exp  <= exp_q;
        end
    end
`endif

    assign locked  = state[1];
    assign exp_out = exp_q;

endmodule

// File: tb/tb_seq_stream_checker.sv
// tb/tb_seq_stream_checker.sv - self-checking bench for seq_stream_checker

module tb_seq_stream_checker;

    localparam int WIDTH    = 4;
    localparam int STEP     = 1;
    localparam int LOCK_CNT = 3;
    localparam int LOSS_CNT = 2;
    localparam int CNT_W    = 4;
    localparam int MOD      = 1 << WIDTH;
    localparam int CMAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] q_in;
    logic             valid_in;
    logic             clear;
    logic             locked;
    logic             err;
    logic [WIDTH-1:0] exp_out;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] err_cnt;
`ifdef SEQ_CHECK_LOG_EN
    logic [WIDTH-1:0] bad_word;
    logic [WIDTH-1:0] bad_exp;
`endif

    seq_stream_checker #(
        .WIDTH(WIDTH), .STEP(STEP), .LOCK_CNT(LOCK_CNT),
        .LOSS_CNT(LOSS_CNT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .q_in(q_in), .valid_in(valid_in),
        .clear(clear), .locked(locked), .err(err), .exp_out(exp_out),
        .match_cnt(match_cnt),
`ifdef SEQ_CHECK_LOG_EN
        .err_cnt(err_cnt), .bad_word(bad_word), .bad_exp(bad_exp)
`else
        .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: "in lock" flag plus one run counter that means
    // consecutive good words while hunting and consecutive misses while locked.
    bit m_lock  = 0;
    int m_run   = 0;
    int m_exp   = 0;
    int m_err   = 0;
    int m_match = 0;
    int m_errc  = 0;
    int m_bword = 0;
    int m_bexp  = 0;

    task automatic model(input bit r, input bit v, input int q, input bit c);
        if (r) begin
            m_lock = 0; m_run = 0; m_exp = 0; m_err = 0;
            m_match = 0; m_errc = 0; m_bword = 0; m_bexp = 0;
            return;
        end
        m_err = 0;
        if (v) begin
            if (!m_lock) begin
                m_run = (m_run > 0 && q == m_exp) ? m_run + 1 : 1;
                m_exp = (q + STEP) % MOD;
                if (m_run >= LOCK_CNT) begin
                    m_lock = 1;
                    m_run  = 0;
                end
            end else begin
                if (q == m_exp) begin
                    m_match = (m_match < CMAX) ? m_match + 1 : CMAX;
                    m_run   = 0;
                end else begin
                    m_err   = 1;
                    m_errc  = (m_errc < CMAX) ? m_errc + 1 : CMAX;
                    m_bword = q;
                    m_bexp  = m_exp;
                    m_run++;
                    if (m_run >= LOSS_CNT) begin
                        m_lock = 0;
                        m_run  = 0;
                    end
                end
                m_exp = (m_exp + STEP) % MOD;
            end
        end
        if (c) begin
            m_match = 0;
            m_errc  = 0;
        end
    endtask

    task automatic step(input bit r, input bit v, input int q, input bit c);
        reset = r; valid_in = v; q_in = WIDTH'(q); clear = c;
        @(posedge clk);
        #1;
        model(r, v, q, c);
        chk("model.locked", int'(locked), int'(m_lock));
        chk("model.err", int'(err), m_err);
        chk("model.exp_out", int'(exp_out), m_exp);
        chk("model.match_cnt", int'(match_cnt), m_match);
        chk("model.err_cnt", int'(err_cnt), m_errc);
`ifdef SEQ_CHECK_LOG_EN
        chk("model.bad_word", int'(bad_word), m_bword);
        chk("model.bad_exp", int'(bad_exp), m_bexp);
`endif
    endtask

    typedef struct {
        bit r; bit v; int q; bit c;
        bit lk; bit er; int ex; int mc; int ec;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit v, input int q, input bit c,
                       input bit lk, input bit er, input int ex, input int mc, input int ec);
        vec_t t;
        t.r = r; t.v = v; t.q = q; t.c = c;
        t.lk = lk; t.er = er; t.ex = ex; t.mc = mc; t.ec = ec;
        tbl.push_back(t);
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; q_in = '0; clear = 1'b0;

        // Reset, then acquire on 0..4.
        add(1,0,0,0, 0,0,0,0,0);
        add(1,0,0,0, 0,0,0,0,0);
        add(0,1,0,0, 0,0,1,0,0);
        add(0,1,1,0, 0,0,2,0,0);
        add(0,1,2,0, 1,0,3,0,0);
        add(0,1,3,0, 1,0,4,1,0);
        add(0,1,4,0, 1,0,5,2,0);
        for (int i = 5; i <= 12; i++) add(0,1,i,0, 1,0,i+1,i-2,0);
        // Wrap 15 -> 0 counts as a match; match_cnt reaches 15 at word 17.
        for (int i = 13; i <= 17; i++) add(0,1,i%MOD,0, 1,0,(i+1)%MOD,i-2,0);
        add(0,1,2,0, 1,0,3,15,0);      // saturated
        add(0,1,3,1, 1,0,4,0,0);       // clear beats increment
        add(0,1,4,0, 1,0,5,1,0);
        add(0,1,5,0, 1,0,6,2,0);
        add(0,1,6,0, 1,0,7,3,0);
        // exp=7: single slip and recovery.
        add(0,1,9,0, 1,1,8,3,1);
        add(0,1,8,0, 1,0,9,4,1);
        // exp=9: two misses lose lock, prediction free-runs.
        add(0,1,3,0, 1,1,10,4,2);
        add(0,1,3,0, 0,1,11,4,3);
        add(0,1,10,0, 0,0,11,4,3);
        add(0,1,11,0, 0,0,12,4,3);
        add(0,1,12,0, 1,0,13,4,3);
        // valid_in low: nothing moves regardless of q_in.
        for (int i = 0; i < 5; i++) add(0,0,int'($urandom_range(0, MOD-1)),0, 1,0,13,4,3);
        add(0,1,13,0, 1,0,14,5,3);
        // Clear in the same cycle as an error increment.
        add(0,1,0,1, 1,1,15,0,0);
        add(0,1,15,0, 1,0,0,1,0);
        // Mid-stream reset ignores the word and forces a fresh acquisition.
        add(1,1,0,0, 0,0,0,0,0);
        add(0,1,5,0, 0,0,6,0,0);
        add(0,1,6,0, 0,0,7,0,0);
        add(0,1,7,0, 1,0,8,0,0);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].v, tbl[i].q, tbl[i].c);
            chk($sformatf("vec%0d.locked", i), int'(locked), int'(tbl[i].lk));
            chk($sformatf("vec%0d.err", i), int'(err), int'(tbl[i].er));
            chk($sformatf("vec%0d.exp_out", i), int'(exp_out), tbl[i].ex);
            chk($sformatf("vec%0d.match_cnt", i), int'(match_cnt), tbl[i].mc);
            chk($sformatf("vec%0d.err_cnt", i), int'(err_cnt), tbl[i].ec);
        end

        // Randomised traffic: mostly in-sequence with injected corruption,
        // gaps, clears and occasional resets, checked against the model.
        for (int n = 0; n < 3000; n++) begin
            bit r, v, c;
            int q;
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 9) < 8);
            c = ($urandom_range(0, 39) == 0);
            q = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, MOD-1)) : m_exp;
            step(r, v, q, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
